// File: rtl/mc_control_if.sv
// Control bundle between the multicycle controller (master) and the MIPS-style
// datapath (slave): instruction/status inputs, mux selects, write enables, debug.
interface mc_control_if #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 32
);
  logic [OP_W-1:0]  op;
  logic             zero;
  logic             mem_ready;
  logic             stall;
  logic [1:0]       pc_src;
  logic             pc_write;
  logic             ior_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [2:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             trap;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, zero, mem_ready, stall,
    output pc_src, pc_write, ior_d, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, trap, state, retired
  );

  modport slave (
    output op, zero, mem_ready, stall,
    input  pc_src, pc_write, ior_d, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, trap, state, retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle controller: sequences fetch/decode/execute/memory/writeback with
// memory wait states, branch resolution, global stall, illegal-op trap, retire count.
module mc_control_fsm #(
  parameter int OP_W          = 4,
  parameter int CNT_W         = 32,
  parameter int MEM_HANDSHAKE = 1
) (
  input logic          clk,
  input logic          reset,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_EXEC_IZ = 4'd4,
    S_EXEC_B  = 4'd5,
    S_EXEC_J  = 4'd6,
    S_ADDR    = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_WB_ALU  = 4'd10,
    S_WB_MEM  = 4'd11,
    S_TRAP    = 4'd15
  } state_t;

  typedef enum logic [2:0] {C_R, C_B, C_J, C_I, C_IZ, C_LD, C_ST, C_ILL} op_class_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic [OP_W-1:0]  op;
  op_class_t        op_class;
  logic             ready;

  assign op    = bus.op;
  assign ready = (MEM_HANDSHAKE == 0) || bus.mem_ready;

  // Only the low nibble is decoded; any set bit above it makes the opcode illegal.
  always_comb begin
    op_class = C_ILL;
    if ((op >> 4) == '0) begin
      case (op[3:0])
        4'b1000, 4'b1100, 4'b1011, 4'b1111:                   op_class = C_R;
        4'b0100, 4'b0101:                                     op_class = C_B;
        4'b0011:                                              op_class = C_J;
        4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110: op_class = C_I;
        4'b0000:                                              op_class = C_IZ;
        4'b0001:                                              op_class = C_LD;
        4'b0010:                                              op_class = C_ST;
        default:                                              op_class = C_ILL;
      endcase
    end
  end

  // NOTE: every output and state_d gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    bus.pc_src     = 2'b00;
    bus.pc_write   = 1'b0;
    bus.ior_d      = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 3'b000;
    bus.alu_op     = 2'b00;
    bus.trap       = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 3'b001;
        if (ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = 3'b010;
        case (op_class)
          C_R:        state_d = S_EXEC_R;
          C_I:        state_d = S_EXEC_I;
          C_IZ:       state_d = S_EXEC_IZ;
          C_B:        state_d = S_EXEC_B;
          C_J:        state_d = S_EXEC_J;
          C_LD, C_ST: state_d = S_ADDR;
          default:    state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 3'b100;
        bus.alu_op    = 2'b11;
        state_d       = S_WB_ALU;
      end
      S_EXEC_IZ: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 3'b011;
        bus.alu_op    = 2'b11;
        state_d       = S_WB_ALU;
      end
      S_EXEC_B: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 2'b01;
        // op[0] separates bne (taken on nonzero) from beq (taken on zero).
        bus.pc_write  = op[0] ? !bus.zero : bus.zero;
        state_d       = S_FETCH;
      end
      S_EXEC_J: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 3'b100;
        state_d       = (op_class == C_ST) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.ior_d    = 1'b1;
        bus.mem_read = 1'b1;
        if (ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        bus.ior_d     = 1'b1;
        bus.mem_write = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (op_class != C_R);
        state_d       = S_FETCH;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.reg_dst    = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: bus.trap = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Stall wins over memory completion: state holds and the access re-issues later.
    if (bus.stall) begin
      state_d       = state_q;
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
    end
    if (reset) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_read  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_FETCH && state_q != S_FETCH)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a per-instruction phase-list model queues the
// expected control word each cycle; a monitor pops and compares against the DUT.
module tb_mc_control_fsm;

  localparam int OP_W  = 6;
  localparam int CNT_W = 4;

  typedef enum {FETCH, DECODE, EXEC_R, EXEC_I, EXEC_IZ, EXEC_B, EXEC_J,
                ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, TRAP} phase_e;
  typedef enum {K_R, K_B, K_J, K_I, K_IZ, K_LD, K_ST, K_ILL} kind_e;

  typedef struct packed {
    logic [1:0]       pc_src;
    logic             pc_write, ior_d, mem_read, mem_write, ir_write, reg_write;
    logic             reg_dst, mem_to_reg, alu_src_a;
    logic [2:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             trap;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mc_control_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus ();

  mc_control_fsm #(.OP_W(OP_W), .CNT_W(CNT_W), .MEM_HANDSHAKE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: each instruction is a list of phases walked one per completed cycle.
  int              code_of[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 15};
  phase_e          plan[$];
  int              idx         = 0;
  bit              need_new    = 1'b1;
  bit              model_valid = 1'b0;
  int              retired_m   = 0;
  logic [OP_W-1:0] cur_op      = '0;
  logic [OP_W-1:0] op_q[$];

  function automatic kind_e kind_of(logic [OP_W-1:0] o);
    int lo = int'(o[3:0]);
    if ((o >> 4) != 0)                    return K_ILL;
    if (lo inside {8, 12, 11, 15})        return K_R;
    if (lo inside {4, 5})                 return K_B;
    if (lo == 3)                          return K_J;
    if (lo inside {9, 10, 13, 14, 7, 6})  return K_I;
    if (lo == 0)                          return K_IZ;
    if (lo == 1)                          return K_LD;
    return K_ST;
  endfunction

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] o = OP_W'($urandom_range(0, 15));
    if ($urandom_range(0, 99) < 6) o = o | OP_W'($urandom_range(1, 3) << 4);
    return o;
  endfunction

  function automatic void start_instr();
    cur_op = (op_q.size() != 0) ? op_q.pop_front() : rand_op();
    plan = '{FETCH, DECODE};
    case (kind_of(cur_op))
      K_R:     begin plan.push_back(EXEC_R);  plan.push_back(WB_ALU); end
      K_I:     begin plan.push_back(EXEC_I);  plan.push_back(WB_ALU); end
      K_IZ:    begin plan.push_back(EXEC_IZ); plan.push_back(WB_ALU); end
      K_B:     plan.push_back(EXEC_B);
      K_J:     plan.push_back(EXEC_J);
      K_LD:    begin plan.push_back(ADDR); plan.push_back(MEM_RD); plan.push_back(WB_MEM); end
      K_ST:    begin plan.push_back(ADDR); plan.push_back(MEM_WR); end
      default: plan.push_back(TRAP);
    endcase
    idx      = 0;
    need_new = 1'b0;
  endfunction

  function automatic obs_t expect_now(phase_e ph, logic rst, logic st, logic mr, logic z);
    obs_t e = '0;
    e.state   = 4'(code_of[ph]);
    e.retired = CNT_W'(retired_m);
    case (ph)
      FETCH:   begin e.mem_read = 1; e.alu_src_b = 3'b001; e.ir_write = mr; e.pc_write = mr; end
      DECODE:  e.alu_src_b = 3'b010;
      EXEC_R:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      EXEC_I:  begin e.alu_src_a = 1; e.alu_src_b = 3'b100; e.alu_op = 2'b11; end
      EXEC_IZ: begin e.alu_src_a = 1; e.alu_src_b = 3'b011; e.alu_op = 2'b11; end
      EXEC_B:  begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
        e.pc_write  = (cur_op[3:0] == 4'b0100) ? z : !z;
      end
      EXEC_J:  begin e.pc_src = 2'b10; e.pc_write = 1; end
      ADDR:    begin e.alu_src_a = 1; e.alu_src_b = 3'b100; end
      MEM_RD:  begin e.ior_d = 1; e.mem_read = 1; end
      MEM_WR:  begin e.ior_d = 1; e.mem_write = 1; end
      WB_ALU:  begin e.reg_write = 1; e.reg_dst = (kind_of(cur_op) != K_R); end
      WB_MEM:  begin e.reg_write = 1; e.mem_to_reg = 1; e.reg_dst = 1; end
      default: e.trap = 1;
    endcase
    if (st || rst) begin
      e.pc_write = 0; e.ir_write = 0; e.mem_write = 0; e.reg_write = 0;
    end
    if (rst) e.mem_read = 0;
    return e;
  endfunction

  task automatic cycle(input logic rst, input logic st, input logic mr, input logic z);
    phase_e ph;
    bit     hold;
    @(negedge clk);
    if (!rst && need_new) start_instr();
    reset         = rst;
    bus.stall     = st;
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.op        = cur_op;
    ph = need_new ? FETCH : plan[idx];
    if (model_valid) exp_q.push_back(expect_now(ph, rst, st, mr, z));
    @(posedge clk);
    hold = st || (ph == TRAP) || ((ph inside {FETCH, MEM_RD, MEM_WR}) && !mr);
    if (rst) begin
      need_new    = 1'b1;
      retired_m   = 0;
      model_valid = 1'b1;
    end else if (!hold) begin
      idx++;
      if (idx == plan.size()) begin
        need_new  = 1'b1;
        retired_m = (retired_m + 1) % (1 << CNT_W);
      end
    end
  endtask

  initial begin : monitor
    obs_t exp_v, act_v;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {bus.pc_src, bus.pc_write, bus.ior_d, bus.mem_read, bus.mem_write,
                 bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                 bus.alu_src_b, bus.alu_op, bus.trap, bus.state, bus.retired};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL ctrl t=%0t op=%b got %h want %h", $time, bus.op, act_v, exp_v);
        end
      end
    end
  end

  initial begin : driver
    bus.op = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1; bus.stall = 1'b0;

    // Reset for two cycles, then an R-type.
    op_q.push_back(6'b001000);
    repeat (2) cycle(1, 0, 1, 0);
    repeat (4) cycle(0, 0, 1, 0);
    // beq taken, beq not taken, bne taken.
    op_q.push_back(6'b000100); repeat (3) cycle(0, 0, 1, 1);
    op_q.push_back(6'b000100); repeat (3) cycle(0, 0, 1, 0);
    op_q.push_back(6'b000101); repeat (3) cycle(0, 0, 1, 0);
    // Load with three wait states in MEM_RD.
    op_q.push_back(6'b000001);
    repeat (3) cycle(0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    repeat (2) cycle(0, 0, 1, 0);
    // Store stalled for two cycles in MEM_WR while memory is ready.
    op_q.push_back(6'b000010);
    repeat (3) cycle(0, 0, 1, 0);
    repeat (2) cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    // Stalled fetch, then sign- and zero-extended immediates.
    op_q.push_back(6'b001001);
    cycle(0, 1, 1, 0);
    repeat (4) cycle(0, 0, 1, 0);
    op_q.push_back(6'b000000); repeat (4) cycle(0, 0, 1, 0);
    // Illegal upper opcode bit traps; reset recovers.
    op_q.push_back(6'b010100);
    repeat (5) cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    // Seventeen jumps wrap the 4-bit counter to 1.
    repeat (17) op_q.push_back(6'b000011);
    repeat (52) cycle(0, 0, 1, 0);
    // Randomized traffic.
    repeat (800) cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15,
                       $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)));

    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
